// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped, write-back data cache.
package dcache_pkg;

    localparam int LINES_DEFAULT = 16;
    localparam int WIDTH_DEFAULT = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WRITEBACK,
        ST_REFILL,
        ST_RESPOND
    } state_t;

    function automatic int idx_width(input int lines);
        return $clog2(lines);
    endfunction

    // Tag covers everything above the index and the 2-bit byte offset.
    function automatic int tag_width(input int width, input int lines);
        return width - $clog2(lines) - 2;
    endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Line storage: tag/data in RAM-style arrays, valid/dirty in resettable flops.
// One registered read port and one write port; a write always marks the line valid.
module dcache_line_store
    import dcache_pkg::*;
#(
    parameter  int LINES = LINES_DEFAULT,
    parameter  int WIDTH = WIDTH_DEFAULT,
    localparam int IDX_W = idx_width(LINES),
    localparam int TAG_W = tag_width(WIDTH, LINES)
) (
    input  logic             i_clk,
    input  logic             i_srst,
    input  logic             i_rd_en,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic             o_rd_valid,
    output logic             o_rd_dirty,
    output logic [TAG_W-1:0] o_rd_tag,
    output logic [WIDTH-1:0] o_rd_data,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [TAG_W-1:0] i_wr_tag,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_wr_dirty
);

    logic [TAG_W-1:0] r_tag_mem  [LINES];
    logic [WIDTH-1:0] r_data_mem [LINES];
    logic [LINES-1:0] r_valid;
    logic [LINES-1:0] r_dirty;
    logic             r_rd_valid;
    logic             r_rd_dirty;
    logic [TAG_W-1:0] r_rd_tag;
    logic [WIDTH-1:0] r_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_tag_mem[i_wr_idx]  <= i_wr_tag;
            r_data_mem[i_wr_idx] <= i_wr_data;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LINES; gi++) begin : g_line_flags
            always_ff @(posedge i_clk) begin
                if (i_srst) begin
                    r_valid[gi] <= 1'b0;
                    r_dirty[gi] <= 1'b0;
                end else if (i_wr_en && (i_wr_idx == IDX_W'(gi))) begin
                    r_valid[gi] <= 1'b1;
                    r_dirty[gi] <= i_wr_dirty;
                end
            end
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_rd_valid <= 1'b0;
            r_rd_dirty <= 1'b0;
        end else if (i_rd_en) begin
            r_rd_valid <= r_valid[i_rd_idx];
            r_rd_dirty <= r_dirty[i_rd_idx];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rd_en) begin
            r_rd_tag  <= r_tag_mem[i_rd_idx];
            r_rd_data <= r_data_mem[i_rd_idx];
        end
    end

    assign o_rd_valid = r_rd_valid;
    assign o_rd_dirty = r_rd_dirty;
    assign o_rd_tag   = r_rd_tag;
    assign o_rd_data  = r_rd_data;

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, one-word-line, write-allocate/write-back data cache with a
// single outstanding request and a simple req/ack backing-memory port.
module data_cache
    import dcache_pkg::*;
#(
    parameter int LINES = LINES_DEFAULT,
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             reqValid,
    output logic             reqReady,
    input  logic [WIDTH-1:0] address,
    input  logic [WIDTH-1:0] writeData,
    input  logic             memReadFlag,
    input  logic             memWriteFlag,
    output logic             respValid,
    output logic [WIDTH-1:0] readData,
    output logic             memReq,
    output logic             memWe,
    output logic [WIDTH-1:0] memAddr,
    output logic [WIDTH-1:0] memWdata,
    input  logic [WIDTH-1:0] memRdata,
    input  logic             memAck,
    output logic [15:0]      missCount
);

    localparam int IDX_W = idx_width(LINES);
    localparam int TAG_W = tag_width(WIDTH, LINES);

    state_t           r_state;
    state_t           w_state_next;
    logic [TAG_W-1:0] r_tag;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_wdata;
    logic             r_is_store;
    logic             r_is_load;
    logic             r_resp_valid;
    logic [WIDTH-1:0] r_read_data;
    logic             r_mem_req;
    logic             r_mem_we;
    logic [WIDTH-1:0] r_mem_addr;
    logic [WIDTH-1:0] r_mem_wdata;
    logic [15:0]      r_miss_count;

    logic             w_accept;
    logic             w_noop;
    logic             w_hit;
    logic             w_victim_dirty;
    logic             w_rd_valid;
    logic             w_rd_dirty;
    logic [TAG_W-1:0] w_rd_tag;
    logic [WIDTH-1:0] w_rd_data;
    logic             w_wr_en;
    logic [WIDTH-1:0] w_wr_data;
    logic             w_wr_dirty;
    logic             w_unused;

    // Byte offset within the word plays no part in the lookup.
    assign w_unused = ^address[1:0];

    assign w_accept       = reqValid && (r_state == ST_IDLE);
    assign w_noop         = !r_is_store && !r_is_load;
    assign w_hit          = w_rd_valid && (w_rd_tag == r_tag);
    assign w_victim_dirty = w_rd_valid && w_rd_dirty;

    dcache_line_store #(
        .LINES (LINES),
        .WIDTH (WIDTH)
    ) u_line_store (
        .i_clk      (clock),
        .i_srst     (reset),
        .i_rd_en    (w_accept),
        .i_rd_idx   (address[IDX_W+1:2]),
        .o_rd_valid (w_rd_valid),
        .o_rd_dirty (w_rd_dirty),
        .o_rd_tag   (w_rd_tag),
        .o_rd_data  (w_rd_data),
        .i_wr_en    (w_wr_en),
        .i_wr_idx   (r_idx),
        .i_wr_tag   (r_tag),
        .i_wr_data  (w_wr_data),
        .i_wr_dirty (w_wr_dirty)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:      if (w_accept) w_state_next = ST_LOOKUP;
            ST_LOOKUP: begin
                if (w_noop || w_hit)  w_state_next = ST_RESPOND;
                else if (w_victim_dirty) w_state_next = ST_WRITEBACK;
                else                  w_state_next = ST_REFILL;
            end
            ST_WRITEBACK: if (memAck) w_state_next = ST_REFILL;
            ST_REFILL:    if (memAck) w_state_next = ST_RESPOND;
            ST_RESPOND:   w_state_next = ST_IDLE;
            default:      w_state_next = ST_IDLE;
        endcase
    end

    // A refill lands clean; a store then overwrites the same line in RESPOND.
    always_comb begin
        w_wr_en    = 1'b0;
        w_wr_data  = memRdata;
        w_wr_dirty = 1'b0;
        if (!reset) begin
            if ((r_state == ST_REFILL) && memAck) begin
                w_wr_en = 1'b1;
            end else if ((r_state == ST_RESPOND) && r_is_store) begin
                w_wr_en    = 1'b1;
                w_wr_data  = r_wdata;
                w_wr_dirty = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_resp_valid <= 1'b0;
            r_read_data  <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_miss_count <= '0;
        end else begin
            r_state      <= w_state_next;
            r_resp_valid <= (w_state_next == ST_RESPOND);
            if (w_accept) begin
                r_tag      <= address[WIDTH-1:IDX_W+2];
                r_idx      <= address[IDX_W+1:2];
                r_wdata    <= writeData;
                r_is_store <= memWriteFlag;
                r_is_load  <= memReadFlag && !memWriteFlag;
            end
            case (r_state)
                ST_LOOKUP: begin
                    if (w_noop) begin
                        r_read_data <= '0;
                    end else if (w_hit) begin
                        if (r_is_load) r_read_data <= w_rd_data;
                    end else begin
                        if (r_miss_count != 16'hFFFF) r_miss_count <= r_miss_count + 16'd1;
                        r_mem_req <= 1'b1;
                        if (w_victim_dirty) begin
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= {w_rd_tag, r_idx, 2'b00};
                            r_mem_wdata <= w_rd_data;
                        end else begin
                            r_mem_we   <= 1'b0;
                            r_mem_addr <= {r_tag, r_idx, 2'b00};
                        end
                    end
                end
                ST_WRITEBACK: begin
                    if (memAck) begin
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= {r_tag, r_idx, 2'b00};
                    end
                end
                ST_REFILL: begin
                    if (memAck) begin
                        r_mem_req <= 1'b0;
                        if (r_is_load) r_read_data <= memRdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign reqReady  = (r_state == ST_IDLE);
    assign respValid = r_resp_valid;
    assign readData  = r_read_data;
    assign memReq    = r_mem_req;
    assign memWe     = r_mem_we;
    assign memAddr   = r_mem_addr;
    assign memWdata  = r_mem_wdata;
    assign missCount = r_miss_count;

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: a line-level cache/memory model predicts
// every response and every memory transfer; directed vectors pin the model.
module tb_data_cache;

    logic        clock = 1'b0;
    logic        reset;
    logic        reqValid;
    logic        reqReady;
    logic [31:0] address;
    logic [31:0] writeData;
    logic        memReadFlag;
    logic        memWriteFlag;
    logic        respValid;
    logic [31:0] readData;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic [31:0] memRdata;
    logic        memAck;
    logic [15:0] missCount;

    always #5 clock = ~clock;

    data_cache dut (
        .clock        (clock),
        .reset        (reset),
        .reqValid     (reqValid),
        .reqReady     (reqReady),
        .address      (address),
        .writeData    (writeData),
        .memReadFlag  (memReadFlag),
        .memWriteFlag (memWriteFlag),
        .respValid    (respValid),
        .readData     (readData),
        .memReq       (memReq),
        .memWe        (memWe),
        .memAddr      (memAddr),
        .memWdata     (memWdata),
        .memRdata     (memRdata),
        .memAck       (memAck),
        .missCount    (missCount)
    );

    typedef struct {
        bit          v;
        bit          d;
        logic [25:0] tag;
        logic [31:0] data;
    } mline_t;

    typedef struct {
        logic [31:0] addr;
        bit          we;
        logic [31:0] wdata;
    } txn_t;

    typedef struct {
        logic [31:0] rdata;
        logic [15:0] miss;
        int          acc;
        bit          fast;
    } resp_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          last_lat = 0;
    bit          ack_enable = 1'b1;
    mline_t      ml [16];
    int          model_miss;
    logic [31:0] model_rdata;
    logic [31:0] mem_mdl [logic [31:0]];
    logic [31:0] mem_dut [logic [31:0]];
    txn_t        txq [$];
    txn_t        txlog [$];
    resp_t       respq [$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            ml[i].v = 1'b0;
            ml[i].d = 1'b0;
        end
        model_miss  = 0;
        model_rdata = '0;
        txq.delete();
        respq.delete();
    endtask

    // Whole-operation view: decide hit/miss, queue the memory traffic, update the line.
    task automatic model_access(input logic [31:0] a, input logic [31:0] wd, input bit rd, input bit wr);
        logic [3:0]  idx;
        logic [25:0] tag;
        logic [31:0] line_addr;
        logic [31:0] victim;
        resp_t       r;
        idx       = a[5:2];
        tag       = a[31:6];
        line_addr = {a[31:2], 2'b00};
        r.fast    = 1'b1;
        if (wr || rd) begin
            if (!(ml[idx].v && ml[idx].tag == tag)) begin
                r.fast = 1'b0;
                if (model_miss < 65535) model_miss++;
                if (ml[idx].v && ml[idx].d) begin
                    victim = {ml[idx].tag, idx, 2'b00};
                    mem_mdl[victim] = ml[idx].data;
                    txq.push_back(txn_t'{victim, 1'b1, ml[idx].data});
                end
                txq.push_back(txn_t'{line_addr, 1'b0, 32'h0});
                ml[idx].v    = 1'b1;
                ml[idx].d    = 1'b0;
                ml[idx].tag  = tag;
                ml[idx].data = mem_mdl.exists(line_addr) ? mem_mdl[line_addr] : dflt(line_addr);
            end
            if (wr) begin
                ml[idx].data = wd;
                ml[idx].d    = 1'b1;
            end else begin
                model_rdata = ml[idx].data;
            end
        end else begin
            model_rdata = '0;
        end
        r.rdata = model_rdata;
        r.miss  = model_miss[15:0];
        r.acc   = cyc;
        respq.push_back(r);
    endtask

    // Caller is positioned just after a rising edge.
    task automatic do_req(input logic [31:0] a, input logic [31:0] wd, input bit rd, input bit wr,
                          input bit wait_done);
        int n;
        n = 0;
        while (!reqReady && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        if (!reqReady) chk("reqReady_timeout", {31'b0, reqReady}, 32'h1);
        address      = a;
        writeData    = wd;
        memReadFlag  = rd;
        memWriteFlag = wr;
        reqValid     = 1'b1;
        @(posedge clock); #1;
        model_access(a, wd, rd, wr);
        reqValid     = 1'b0;
        memReadFlag  = 1'b0;
        memWriteFlag = 1'b0;
        if (wait_done) begin
            n = 0;
            while (respq.size() > 0 && n < 200) begin
                @(posedge clock); #1;
                n++;
            end
            if (respq.size() > 0) chk("resp_timeout", respq.size(), 32'h0);
            $display("req addr=%h wd=%h rd=%0d wr=%0d -> readData=%h missCount=%0d", a, wd, rd, wr,
                     readData, missCount);
        end
    endtask

    // Backing memory: acknowledges 3 cycles after it sees a request.
    initial begin : responder
        int          wait_cnt;
        logic [31:0] a;
        memAck   = 1'b0;
        memRdata = '0;
        wait_cnt = 0;
        forever begin
            @(posedge clock); #1;
            memAck = 1'b0;
            if (reset || !ack_enable || !memReq) begin
                wait_cnt = 0;
            end else begin
                wait_cnt++;
                if (wait_cnt == 3) begin
                    a = memAddr;
                    if (memWe) mem_dut[a] = memWdata;
                    memRdata = mem_dut.exists(a) ? mem_dut[a] : dflt(a);
                    memAck   = 1'b1;
                    wait_cnt = 0;
                end
            end
        end
    end

    initial begin : compare
        bit   in_txn;
        txn_t cur;
        txn_t t;
        resp_t r;
        in_txn = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                in_txn = 1'b0;
                continue;
            end
            if (respValid) begin
                if (respq.size() == 0) begin
                    chk("unexpected_respValid", {31'b0, respValid}, 32'h0);
                end else begin
                    r = respq.pop_front();
                    chk("readData", readData, r.rdata);
                    chk("missCount", {16'h0, missCount}, {16'h0, r.miss});
                    last_lat = cyc - r.acc;
                    if (r.fast) chk("short_latency", last_lat, 32'd1);
                end
            end
            if (memReq) begin
                if (!in_txn) begin
                    cur = txn_t'{memAddr, memWe, memWdata};
                    txlog.push_back(cur);
                    $display("mem txn addr=%h we=%0d wdata=%h", memAddr, memWe, memWdata);
                    if (txq.size() == 0) begin
                        chk("unexpected_memReq", {31'b0, memReq}, 32'h0);
                    end else begin
                        t = txq.pop_front();
                        chk("memAddr", memAddr, t.addr);
                        chk("memWe", {31'b0, memWe}, {31'b0, t.we});
                        if (t.we) chk("memWdata", memWdata, t.wdata);
                    end
                    in_txn = 1'b1;
                end else begin
                    chk("memAddr_stable", memAddr, cur.addr);
                    chk("memWe_stable", {31'b0, memWe}, {31'b0, cur.we});
                    chk("memWdata_stable", memWdata, cur.wdata);
                end
            end
            if (memAck) in_txn = 1'b0;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    logic [31:0] tbl_addr [8] = '{32'h104, 32'h106, 32'h144, 32'h104, 32'h3C, 32'h7C, 32'h3C, 32'h7C};
    logic [31:0] tbl_wd   [8] = '{32'h1111_1111, 0, 0, 0, 32'hAAAA_5555, 32'h0BAD_F00D, 0, 0};
    bit          tbl_rd   [8] = '{0, 1, 1, 1, 0, 0, 1, 1};
    bit          tbl_wr   [8] = '{1, 0, 0, 0, 1, 1, 0, 0};

    initial begin : main
        int n;
        reset        = 1'b1;
        reqValid     = 1'b0;
        address      = '0;
        writeData    = '0;
        memReadFlag  = 1'b0;
        memWriteFlag = 1'b0;
        mem_mdl[32'h10] = 32'hDEAD_BEEF;
        mem_dut[32'h10] = 32'hDEAD_BEEF;
        model_reset();

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_respValid", {31'b0, respValid}, 32'h0);
        chk("rst_readData", readData, 32'h0);
        chk("rst_memReq", {31'b0, memReq}, 32'h0);
        chk("rst_memWe", {31'b0, memWe}, 32'h0);
        chk("rst_memAddr", memAddr, 32'h0);
        chk("rst_memWdata", memWdata, 32'h0);
        chk("rst_missCount", {16'h0, missCount}, 32'h0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("reqReady_after_reset", {31'b0, reqReady}, 32'h1);
        @(posedge clock); #1;

        // Cold read miss, then hit
        txlog.delete();
        do_req(32'h10, 32'h0, 1, 0, 1);
        chk("cold_readData", readData, 32'hDEAD_BEEF);
        chk("cold_missCount", {16'h0, missCount}, 32'h1);
        chk("cold_txn_count", txlog.size(), 32'd1);
        if (txlog.size() >= 1) begin
            chk("cold_memAddr", txlog[0].addr, 32'h10);
            chk("cold_memWe", {31'b0, txlog[0].we}, 32'h0);
        end
        txlog.delete();
        do_req(32'h10, 32'h0, 1, 0, 1);
        chk("hit_latency", last_lat, 32'd1);
        chk("hit_missCount", {16'h0, missCount}, 32'h1);
        chk("hit_no_memReq", txlog.size(), 32'd0);

        // Dirty eviction
        do_req(32'h10, 32'h1234_5678, 0, 1, 1);
        txlog.delete();
        do_req(32'h50, 32'h0, 1, 0, 1);
        chk("evict_txn_count", txlog.size(), 32'd2);
        if (txlog.size() >= 2) begin
            chk("wb_memAddr", txlog[0].addr, 32'h10);
            chk("wb_memWe", {31'b0, txlog[0].we}, 32'h1);
            chk("wb_memWdata", txlog[0].wdata, 32'h1234_5678);
            chk("refill_memAddr", txlog[1].addr, 32'h50);
            chk("refill_memWe", {31'b0, txlog[1].we}, 32'h0);
        end
        chk("evict_readData", readData, 32'hA5A5_0050);
        chk("evict_missCount", {16'h0, missCount}, 32'h2);

        // Both flags set behaves as a store
        do_req(32'h20, 32'h5, 1, 1, 1);
        do_req(32'h20, 32'h0, 1, 0, 1);
        chk("bothflags_readData", readData, 32'h5);
        chk("bothflags_missCount", {16'h0, missCount}, 32'h3);

        // No-op
        txlog.delete();
        do_req(32'h30, 32'hFFFF_FFFF, 0, 0, 1);
        chk("noop_readData", readData, 32'h0);
        chk("noop_missCount", {16'h0, missCount}, 32'h3);
        chk("noop_latency", last_lat, 32'd1);
        chk("noop_no_memReq", txlog.size(), 32'd0);

        // Mixed conflict traffic on lines 1 and 15
        for (int i = 0; i < 8; i++) do_req(tbl_addr[i], tbl_wd[i], tbl_rd[i], tbl_wr[i], 1);
        chk("table_last_readData", readData, 32'h0BAD_F00D);

        // Reset in the middle of a refill
        ack_enable = 1'b0;
        do_req(32'h10, 32'h0, 1, 0, 0);
        n = 0;
        while (!memReq && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        chk("abort_refill_started", {31'b0, memReq}, 32'h1);
        @(posedge clock); #1;
        reset = 1'b1;
        model_reset();
        @(posedge clock);
        @(negedge clock);
        chk("abort_memReq", {31'b0, memReq}, 32'h0);
        @(posedge clock); #1;
        reset      = 1'b0;
        ack_enable = 1'b1;
        @(negedge clock);
        chk("abort_reqReady", {31'b0, reqReady}, 32'h1);
        @(posedge clock); #1;
        do_req(32'h10, 32'h0, 1, 0, 1);
        chk("abort_reload_missCount", {16'h0, missCount}, 32'h1);
        chk("abort_reload_readData", readData, 32'h1234_5678);

        repeat (3) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
